// File: rtl/inst_ram_if.sv
// Bus interface for inst_ram_256x8.
//   master : fetch stage / loader side (drives read address/enable and the write port)
//   slave  : memory side (drives DataOut, and AddrErr when INST_RAM_RANGE_CHK_EN is defined)
// Signals:
//   Enable, Address -> read request; DataOut <- registered 32-bit big-endian word
//   WrEn, WrAddr, WrData -> byte write port
//   AddrErr <- out-of-range flag (only with INST_RAM_RANGE_CHK_EN)
interface inst_ram_if #(
    parameter int AW = 32
);
    logic          Enable;
    logic [AW-1:0] Address;
    logic [31:0]   DataOut;
    logic          WrEn;
    logic [AW-1:0] WrAddr;
    logic [7:0]    WrData;
`ifdef INST_RAM_RANGE_CHK_EN
    logic          AddrErr;

    modport master (output Enable, Address, WrEn, WrAddr, WrData,
                    input  DataOut, AddrErr);
    modport slave  (input  Enable, Address, WrEn, WrAddr, WrData,
                    output DataOut, AddrErr);
`else
    modport master (output Enable, Address, WrEn, WrAddr, WrData,
                    input  DataOut);
    modport slave  (input  Enable, Address, WrEn, WrAddr, WrData,
                    output DataOut);
`endif
endinterface

// File: rtl/inst_ram_256x8.sv
// inst_ram_256x8: byte-organised instruction memory (DEPTH bytes).
// Any byte address may be read; the read returns four consecutive bytes as a
// big-endian 32-bit word (byte at the address in [31:24]), wrapping at DEPTH.
// Read latency is one clock; DataOut holds while Enable=0. A byte-wide write
// port loads the program. Same-edge read/write overlap returns the old byte.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears DataOut (and AddrErr), not Mem
//   bus    inst_ram_if.slave (Enable, Address, DataOut, WrEn, WrAddr, WrData[, AddrErr])
// Optional feature macro: INST_RAM_RANGE_CHK_EN
//   Adds AddrErr (address bits above the index are non-zero, registered with
//   the read) and drops writes whose WrAddr is out of range.
module inst_ram_256x8 #(
    parameter int DEPTH = 256,
    parameter int AW    = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    inst_ram_if.slave   bus
);
    localparam int IW = $clog2(DEPTH);

    // Storage keeps its name so benches can reach it hierarchically.
    logic [7:0] Mem [0:DEPTH-1];

    logic [IW-1:0] rd_idx0, rd_idx1, rd_idx2, rd_idx3;
    logic [IW-1:0] wr_idx;
    logic [31:0]   rd_word;
    logic [31:0]   data_out_d, data_out_q;
    logic          wr_ok;

    // Index arithmetic is done at index width so byte offsets wrap mod DEPTH.
    assign rd_idx0 = bus.Address[IW-1:0];
    assign rd_idx1 = rd_idx0 + IW'(1);
    assign rd_idx2 = rd_idx0 + IW'(2);
    assign rd_idx3 = rd_idx0 + IW'(3);
    assign wr_idx  = bus.WrAddr[IW-1:0];

`ifdef INST_RAM_RANGE_CHK_EN
    logic rd_oor, wr_oor;
    logic addr_err_d, addr_err_q;

    assign rd_oor = |bus.Address[AW-1:IW];
    assign wr_oor = |bus.WrAddr[AW-1:IW];
`else
    // Upper address bits are deliberately ignored in this build.
    logic unused_hi;
    assign unused_hi = ^{bus.Address[AW-1:IW], bus.WrAddr[AW-1:IW]};
`endif

    always_comb begin
        rd_word    = {Mem[rd_idx0], Mem[rd_idx1], Mem[rd_idx2], Mem[rd_idx3]};
        data_out_d = data_out_q;
        if (bus.Enable) data_out_d = rd_word;
`ifdef INST_RAM_RANGE_CHK_EN
        addr_err_d = addr_err_q;
        if (bus.Enable) addr_err_d = rd_oor;
        wr_ok      = bus.WrEn && !wr_oor;
`else
        wr_ok      = bus.WrEn;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q <= '0;
        end else begin
            data_out_q <= data_out_d;
        end
    end

`ifdef INST_RAM_RANGE_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= addr_err_d;
        end
    end

    assign bus.AddrErr = addr_err_q;
`endif

    // Memory has no reset; writes are blocked while reset is held. The read
    // above sees pre-edge contents, giving read-before-write on overlap.
    always_ff @(posedge clk) begin
        if (rst_n && wr_ok) Mem[wr_idx] <= bus.WrData;
    end

    assign bus.DataOut = data_out_q;

endmodule

// File: tb/tb_inst_ram_256x8.sv
// Scoreboard bench for inst_ram_256x8: the driver pushes the expected word for
// every clocked cycle; a monitor pops and compares after each rising edge.
module tb_inst_ram_256x8;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    inst_ram_if #(.AW(32)) bus ();

    inst_ram_256x8 #(.DEPTH(256), .AW(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: plain byte array plus the value the output should hold.
    logic [7:0]  model [256];
    logic [31:0] hold_data = 32'h0;
    logic        hold_err  = 1'b0;

    function automatic logic [31:0] model_word(input logic [31:0] addr);
        int a;
        a = int'(addr % 256);
        return {model[a], model[(a + 1) % 256], model[(a + 2) % 256], model[(a + 3) % 256]};
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    // One clocked cycle of stimulus. use_c selects a hand-computed expected word.
    task automatic step(input logic en, input logic [31:0] addr, input logic we,
                        input logic [31:0] waddr, input logic [7:0] wdata,
                        input bit use_c, input logic [31:0] c, input string tag);
        exp_t e;
        @(negedge clk);
        bus.Enable  = en;
        bus.Address = addr;
        bus.WrEn    = we;
        bus.WrAddr  = waddr;
        bus.WrData  = wdata;
        if (en) begin
            hold_data = use_c ? c : model_word(addr);
            hold_err  = |addr[31:8];
        end
        e.data = hold_data;
        e.err  = hold_err;
        e.tag  = tag;
        exp_q.push_back(e);
`ifdef INST_RAM_RANGE_CHK_EN
        if (we && waddr[31:8] == 24'h0) model[waddr[7:0]] = wdata;
`else
        if (we) model[waddr[7:0]] = wdata;
`endif
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        step(1'b0, 32'h0, 1'b1, a, d, 1'b0, 32'h0, "wr_hold");
    endtask

    // Monitor: the output registered at an edge is compared 2 time units later.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.tag, bus.DataOut, e.data);
`ifdef INST_RAM_RANGE_CHK_EN
                check({e.tag, "_err"}, {31'h0, bus.AddrErr}, {31'h0, e.err});
`endif
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        bus.Enable  = 1'b0;
        bus.Address = '0;
        bus.WrEn    = 1'b0;
        bus.WrAddr  = '0;
        bus.WrData  = '0;
        #3;
        check("reset_dataout", bus.DataOut, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Load every byte with random data through the write port.
        for (int i = 0; i < 256; i++) wr(i, 8'($urandom));

        // Directed program image.
        wr(0, 8'hE3); wr(1, 8'hA0); wr(2, 8'h10); wr(3, 8'h05); wr(4, 8'h7F);
        step(1'b1, 32'd0, 1'b0, 32'd0, 8'h0, 1'b1, 32'hE3A01005, "aligned_rd");
        step(1'b1, 32'd1, 1'b0, 32'd0, 8'h0, 1'b1, 32'hA010057F, "unaligned_rd");

        // Wrap across the top of the array.
        wr(254, 8'h11); wr(255, 8'h22); wr(0, 8'h33); wr(1, 8'h44);
        step(1'b1, 32'd254, 1'b0, 32'd0, 8'h0, 1'b1, 32'h11223344, "wrap_rd");
        wr(0, 8'hE3); wr(1, 8'hA0);
        step(1'b1, 32'd0, 1'b0, 32'd0, 8'h0, 1'b1, 32'hE3A01005, "restore_rd");

        // Enable low: output holds while address moves.
        for (int i = 0; i < 3; i++)
            step(1'b0, 32'($urandom_range(0, 255)), 1'b0, 32'd0, 8'h0, 1'b0, 32'h0, "hold");

        // Same-edge write/read overlap returns the old byte, then the new one.
        step(1'b1, 32'd0, 1'b1, 32'd2, 8'hAA, 1'b1, 32'hE3A01005, "rbw_old");
        step(1'b1, 32'd0, 1'b0, 32'd0, 8'h0, 1'b1, 32'hE3A0AA05, "rbw_new");

        // Reset pulse between edges, held across one edge with a write attempt.
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check("async_reset", bus.DataOut, 32'h0);
        bus.Enable = 1'b1; bus.Address = 32'd0;
        bus.WrEn = 1'b1; bus.WrAddr = 32'd0; bus.WrData = 8'hFF;
        @(posedge clk);
        #2 check("reset_held", bus.DataOut, 32'h0);
        @(negedge clk);
        bus.Enable = 1'b0; bus.WrEn = 1'b0;
        rst_n = 1'b1;
        hold_data = 32'h0;
        hold_err  = 1'b0;
        step(1'b1, 32'd0, 1'b0, 32'd0, 8'h0, 1'b1, 32'hE3A0AA05, "post_reset_rd");

        // Random traffic, including large addresses and overlapping writes.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ra, wa;
            ra = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 255));
            wa = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 255));
            step(1'($urandom), ra, 1'($urandom), wa, 8'($urandom), 1'b0, 32'h0, "random");
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
